// File: rtl/kp_ranked_fifo_if.sv
// kp_ranked_fifo_if: push/pop bus of the ranked keypoint buffer
// Push side: i_push, i_coor_x, i_coor_y, i_score, i_desc; flush: i_clear
// Pop side:  i_pop, o_valid, o_coor_x, o_coor_y, o_score, o_desc
// Status:    o_count, o_full, o_drop, o_evict
interface kp_ranked_fifo_if #(
   parameter int DEPTH   = 100,
   parameter int COOR_W  = 10,
   parameter int SCORE_W = 8,
   parameter int DESC_W  = 256
);
   logic                       i_clear;
   logic                       i_push;
   logic [COOR_W-1:0]          i_coor_x;
   logic [COOR_W-1:0]          i_coor_y;
   logic [SCORE_W-1:0]         i_score;
   logic [DESC_W-1:0]          i_desc;
   logic                       i_pop;
   logic                       o_valid;
   logic [COOR_W-1:0]          o_coor_x;
   logic [COOR_W-1:0]          o_coor_y;
   logic [SCORE_W-1:0]         o_score;
   logic [DESC_W-1:0]          o_desc;
   logic [$clog2(DEPTH+1)-1:0] o_count;
   logic                       o_full;
   logic                       o_drop;
   logic                       o_evict;
   modport master (
      output i_clear, i_push, i_coor_x, i_coor_y, i_score, i_desc, i_pop,
      input  o_valid, o_coor_x, o_coor_y, o_score, o_desc, o_count, o_full, o_drop, o_evict
   );
   modport slave (
      input  i_clear, i_push, i_coor_x, i_coor_y, i_score, i_desc, i_pop,
      output o_valid, o_coor_x, o_coor_y, o_score, o_desc, o_count, o_full, o_drop, o_evict
   );
endinterface

// File: rtl/kp_ranked_fifo.sv
// kp_ranked_fifo: keypoint FIFO that, when full, drops or replaces the weakest entry
// i_clk, i_rst_n (async, active-low); bus: kp_ranked_fifo_if slave
// Head fields are a combinational read at the read pointer, zeroed while empty.
// o_count/o_drop/o_evict are registered and report the event of the last edge.
module kp_ranked_fifo #(
   parameter int DEPTH   = 100,
   parameter int COOR_W  = 10,
   parameter int SCORE_W = 8,
   parameter int DESC_W  = 256,
   parameter int REPLACE = 1
) (
   input logic              i_clk,
   input logic              i_rst_n,
   kp_ranked_fifo_if.slave  bus
);
   localparam int              PW      = $clog2(DEPTH);
   localparam int              CW      = $clog2(DEPTH+1);
   localparam logic [PW:0]     DEPTH_P = (PW+1)'(DEPTH);
   localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
   localparam logic [PW-1:0]   LAST    = PW'(DEPTH-1);
   logic [COOR_W-1:0]  r_x [DEPTH];
   logic [COOR_W-1:0]  r_y [DEPTH];
   logic [SCORE_W-1:0] r_s [DEPTH];
   logic [DESC_W-1:0]  r_d [DEPTH];
   logic [PW-1:0]      r_rd, r_wr, w_min_idx, w_waddr;
   logic [PW:0]        w_pos;
   logic [SCORE_W-1:0] w_min;
   logic [CW-1:0]      r_cnt;
   logic               r_drop, r_evict;
   logic               w_lt, w_valid, w_full, w_pop, w_block, w_wr, w_rep, w_drop;
   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + PW'(1);
   endfunction
   assign w_valid = r_cnt != '0;
   assign w_full  = r_cnt == DEPTH_C;
   assign w_pop   = bus.i_pop & w_valid;
   // a push with nowhere to go: full and not freed by a same-cycle pop
   assign w_block = bus.i_push & w_full & ~w_pop;
   assign w_wr    = bus.i_push & ~w_block;
   assign w_rep   = w_block & (REPLACE != 0) & (bus.i_score > w_min);
   assign w_drop  = w_block & ~w_rep;
   assign w_waddr = w_rep ? w_min_idx : r_wr;
   // oldest-first scan with strict less-than so ties keep the oldest entry
   always_comb begin
      w_pos     = '0;
      w_lt      = 1'b0;
      w_min     = r_s[r_rd];
      w_min_idx = r_rd;
      for (int k = 1; k < DEPTH; k++) begin
         w_pos     = {1'b0, r_rd} + (PW+1)'(k);
         w_pos     = (w_pos >= DEPTH_P) ? w_pos - DEPTH_P : w_pos;
         w_lt      = r_s[w_pos[PW-1:0]] < w_min;
         w_min_idx = w_lt ? w_pos[PW-1:0] : w_min_idx;
         w_min     = w_lt ? r_s[w_pos[PW-1:0]] : w_min;
      end
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_cnt   <= '0;
         r_drop  <= 1'b0;
         r_evict <= 1'b0;
      end else if (bus.i_clear) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_cnt   <= '0;
         r_drop  <= 1'b0;
         r_evict <= 1'b0;
      end else begin
         r_rd    <= w_pop ? inc(r_rd) : r_rd;
         r_wr    <= w_wr ? inc(r_wr) : r_wr;
         r_cnt   <= r_cnt + CW'(w_wr) - CW'(w_pop);
         r_drop  <= w_drop;
         r_evict <= w_rep;
      end
   end
   always_ff @(posedge i_clk) begin
      if (!bus.i_clear && (w_wr || w_rep)) begin
         r_x[w_waddr] <= bus.i_coor_x;
         r_y[w_waddr] <= bus.i_coor_y;
         r_s[w_waddr] <= bus.i_score;
         r_d[w_waddr] <= bus.i_desc;
      end
   end
   assign bus.o_valid  = w_valid;
   assign bus.o_coor_x = w_valid ? r_x[r_rd] : '0;
   assign bus.o_coor_y = w_valid ? r_y[r_rd] : '0;
   assign bus.o_score  = w_valid ? r_s[r_rd] : '0;
   assign bus.o_desc   = w_valid ? r_d[r_rd] : '0;
   assign bus.o_count  = r_cnt;
   assign bus.o_full   = w_full;
   assign bus.o_drop   = r_drop;
   assign bus.o_evict  = r_evict;
endmodule

// File: tb/tb_kp_ranked_fifo.sv
// tb_kp_ranked_fifo: scoreboard bench for kp_ranked_fifo (REPLACE=1 and REPLACE=0 copies)
module tb_kp_ranked_fifo;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   kp_ranked_fifo_if #(.DEPTH(4), .COOR_W(10), .SCORE_W(8), .DESC_W(256)) ifr ();
   kp_ranked_fifo_if #(.DEPTH(4), .COOR_W(10), .SCORE_W(8), .DESC_W(256)) ifd ();
   kp_ranked_fifo #(.DEPTH(4), .COOR_W(10), .SCORE_W(8), .DESC_W(256), .REPLACE(1))
      u_rep (.i_clk(clk), .i_rst_n(rst_n), .bus(ifr));
   kp_ranked_fifo #(.DEPTH(4), .COOR_W(10), .SCORE_W(8), .DESC_W(256), .REPLACE(0))
      u_drp (.i_clk(clk), .i_rst_n(rst_n), .bus(ifd));
   function automatic logic [9:0] fx(input logic [7:0] s);
      return {s, 2'b01};
   endfunction
   function automatic logic [9:0] fy(input logic [7:0] s);
      return {2'b10, ~s};
   endfunction
   function automatic logic [255:0] fd(input logic [7:0] s);
      return {32{s ^ 8'h5A}};
   endfunction
   logic       sel = 1'b1, p_push = 1'b0, p_pop = 1'b0, p_clr = 1'b0;
   logic [7:0] p_sc = '0;
   assign ifr.i_clear  = sel & p_clr;
   assign ifr.i_push   = sel & p_push;
   assign ifr.i_pop    = sel & p_pop;
   assign ifr.i_score  = sel ? p_sc : '0;
   assign ifr.i_coor_x = sel ? fx(p_sc) : '0;
   assign ifr.i_coor_y = sel ? fy(p_sc) : '0;
   assign ifr.i_desc   = sel ? fd(p_sc) : '0;
   assign ifd.i_clear  = ~sel & p_clr;
   assign ifd.i_push   = ~sel & p_push;
   assign ifd.i_pop    = ~sel & p_pop;
   assign ifd.i_score  = ~sel ? p_sc : '0;
   assign ifd.i_coor_x = ~sel ? fx(p_sc) : '0;
   assign ifd.i_coor_y = ~sel ? fy(p_sc) : '0;
   assign ifd.i_desc   = ~sel ? fd(p_sc) : '0;
   int total = 0;
   int bad = 0;
   logic [7:0] q_r[$];
   logic [7:0] q_d[$];
   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask
   task automatic chkd(input string nm, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   // monitor: each accepted pop must present the oldest expected keypoint
   always @(negedge clk) begin
      int e;
      if (ifr.i_pop && ifr.o_valid) begin
         e = (q_r.size() != 0) ? int'(q_r.pop_front()) : -1;
         chk("rep_head_score", ifr.o_score, e);
         chk("rep_head_x", ifr.o_coor_x, fx(8'(e)));
         chk("rep_head_y", ifr.o_coor_y, fy(8'(e)));
         chkd("rep_head_desc", ifr.o_desc, fd(8'(e)));
      end
      if (ifd.i_pop && ifd.o_valid) begin
         e = (q_d.size() != 0) ? int'(q_d.pop_front()) : -1;
         chk("drp_head_score", ifd.o_score, e);
         chk("drp_head_x", ifd.o_coor_x, fx(8'(e)));
         chkd("drp_head_desc", ifd.o_desc, fd(8'(e)));
      end
   end
   task automatic step(input logic s, input logic push, input logic [7:0] sc, input logic pop, input logic clr);
      sel = s;
      p_push = push;
      p_sc = sc;
      p_pop = pop;
      p_clr = clr;
      @(posedge clk);
      #1;
   endtask
   task automatic push_chk(input logic s, input logic [7:0] sc, input int cnt, input string nm);
      step(s, 1'b1, sc, 1'b0, 1'b0);
      chk(nm, s ? int'(ifr.o_count) : int'(ifd.o_count), cnt);
   endtask
   task automatic pop_chk(input logic s, input int cnt, input string nm);
      step(s, 1'b0, 8'd0, 1'b1, 1'b0);
      chk(nm, s ? int'(ifr.o_count) : int'(ifd.o_count), cnt);
   endtask
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end
   initial begin
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_valid", ifr.o_valid, 0);
      chk("rst_count", ifr.o_count, 0);
      chk("rst_full", ifr.o_full, 0);
      chk("rst_score", ifr.o_score, 0);
      chk("rst_pulses", {ifr.o_drop, ifr.o_evict}, 0);
      // basic order and occupancy
      q_r.push_back(8'd10); q_r.push_back(8'd20); q_r.push_back(8'd30);
      push_chk(1, 8'd10, 1, "t1_cnt_push1");
      push_chk(1, 8'd20, 2, "t1_cnt_push2");
      push_chk(1, 8'd30, 3, "t1_cnt_push3");
      pop_chk(1, 2, "t1_cnt_pop1");
      pop_chk(1, 1, "t1_cnt_pop2");
      pop_chk(1, 0, "t1_cnt_pop3");
      chk("t1_empty_valid", ifr.o_valid, 0);
      chk("t1_empty_score", ifr.o_score, 0);
      chk("t1_empty_x", ifr.o_coor_x, 0);
      chkd("t1_empty_desc", ifr.o_desc, '0);
      // continuous push+pop across pointer wrap
      for (int i = 0; i < 10; i++) q_r.push_back(8'(11 + i));
      push_chk(1, 8'd11, 1, "t2_cnt_first");
      for (int i = 1; i < 10; i++) begin
         step(1, 1'b1, 8'(11 + i), 1'b1, 1'b0);
         chk("t2_cnt_stream", ifr.o_count, 1);
      end
      pop_chk(1, 0, "t2_cnt_last");
      // drop policy when full
      q_d.push_back(8'd5); q_d.push_back(8'd6); q_d.push_back(8'd7); q_d.push_back(8'd8);
      push_chk(0, 8'd5, 1, "t3_cnt1");
      push_chk(0, 8'd6, 2, "t3_cnt2");
      push_chk(0, 8'd7, 3, "t3_cnt3");
      push_chk(0, 8'd8, 4, "t3_cnt4");
      chk("t3_full", ifd.o_full, 1);
      step(0, 1'b1, 8'd9, 1'b0, 1'b0);
      chk("t3_drop", ifd.o_drop, 1);
      chk("t3_no_evict", ifd.o_evict, 0);
      chk("t3_cnt_after_drop", ifd.o_count, 4);
      step(0, 1'b0, 8'd0, 1'b0, 1'b0);
      chk("t3_drop_one_cycle", ifd.o_drop, 0);
      pop_chk(0, 3, "t3_pop1");
      pop_chk(0, 2, "t3_pop2");
      pop_chk(0, 1, "t3_pop3");
      pop_chk(0, 0, "t3_pop4");
      // replace policy: weakest oldest goes, ties and weaker pushes drop
      push_chk(1, 8'd9, 1, "t4_cnt1");
      push_chk(1, 8'd3, 2, "t4_cnt2");
      push_chk(1, 8'd7, 3, "t4_cnt3");
      push_chk(1, 8'd3, 4, "t4_cnt4");
      step(1, 1'b1, 8'd5, 1'b0, 1'b0);
      chk("t4_evict", ifr.o_evict, 1);
      chk("t4_evict_no_drop", ifr.o_drop, 0);
      chk("t4_evict_cnt", ifr.o_count, 4);
      step(1, 1'b1, 8'd2, 1'b0, 1'b0);
      chk("t4_weak_drop", ifr.o_drop, 1);
      chk("t4_weak_no_evict", ifr.o_evict, 0);
      step(1, 1'b1, 8'd3, 1'b0, 1'b0);
      chk("t4_tie_drop", ifr.o_drop, 1);
      step(1, 1'b0, 8'd0, 1'b0, 1'b0);
      chk("t4_drop_clear", ifr.o_drop, 0);
      q_r.push_back(8'd9); q_r.push_back(8'd5); q_r.push_back(8'd7); q_r.push_back(8'd3);
      pop_chk(1, 3, "t4_pop1");
      pop_chk(1, 2, "t4_pop2");
      pop_chk(1, 1, "t4_pop3");
      pop_chk(1, 0, "t4_pop4");
      push_chk(1, 8'd3, 1, "t4b_cnt1");
      push_chk(1, 8'd6, 2, "t4b_cnt2");
      push_chk(1, 8'd7, 3, "t4b_cnt3");
      push_chk(1, 8'd8, 4, "t4b_cnt4");
      step(1, 1'b1, 8'd4, 1'b0, 1'b0);
      chk("t4b_evict", ifr.o_evict, 1);
      chk("t4b_head_now4", ifr.o_score, 4);
      q_r.push_back(8'd4); q_r.push_back(8'd6); q_r.push_back(8'd7); q_r.push_back(8'd8);
      pop_chk(1, 3, "t4b_pop1");
      pop_chk(1, 2, "t4b_pop2");
      pop_chk(1, 1, "t4b_pop3");
      pop_chk(1, 0, "t4b_pop4");
      // full with simultaneous push+pop
      q_r.push_back(8'd1); q_r.push_back(8'd2); q_r.push_back(8'd3); q_r.push_back(8'd4); q_r.push_back(8'd9);
      push_chk(1, 8'd1, 1, "t5_cnt1");
      push_chk(1, 8'd2, 2, "t5_cnt2");
      push_chk(1, 8'd3, 3, "t5_cnt3");
      push_chk(1, 8'd4, 4, "t5_cnt4");
      step(1, 1'b1, 8'd9, 1'b1, 1'b0);
      chk("t5_cnt_pp", ifr.o_count, 4);
      chk("t5_head2", ifr.o_score, 2);
      chk("t5_no_pulses", {ifr.o_drop, ifr.o_evict}, 0);
      pop_chk(1, 3, "t5_pop1");
      pop_chk(1, 2, "t5_pop2");
      pop_chk(1, 1, "t5_pop3");
      pop_chk(1, 0, "t5_pop4");
      // clear beats push; async reset clears outputs at once
      push_chk(1, 8'd1, 1, "t6_cnt1");
      push_chk(1, 8'd2, 2, "t6_cnt2");
      push_chk(1, 8'd3, 3, "t6_cnt3");
      step(1, 1'b1, 8'd7, 1'b0, 1'b1);
      chk("t6_clear_cnt", ifr.o_count, 0);
      chk("t6_clear_valid", ifr.o_valid, 0);
      push_chk(1, 8'd4, 1, "t6_cnt4");
      push_chk(1, 8'd5, 2, "t6_cnt5");
      p_push = 1'b1;
      p_sc = 8'd6;
      #2 rst_n = 1'b0;
      #1;
      chk("t6_arst_valid", ifr.o_valid, 0);
      chk("t6_arst_cnt", ifr.o_count, 0);
      chk("t6_arst_score", ifr.o_score, 0);
      chk("t6_arst_flags", {ifr.o_full, ifr.o_drop, ifr.o_evict}, 0);
      p_push = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 1'b0, 8'd0, 1'b0, 1'b0);
      chk("t6_after_rst_cnt", ifr.o_count, 0);
      q_r.push_back(8'd7);
      push_chk(1, 8'd7, 1, "t6_resume_push");
      pop_chk(1, 0, "t6_resume_pop");
      step(1, 1'b0, 8'd0, 1'b0, 1'b0);
      chk("rep_queue_left", q_r.size(), 0);
      chk("drp_queue_left", q_d.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
